// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the two-input gate vector checker.
// Holds the FSM state type, the Gray-ordered vector table and the reference truth table.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_VECS = 4;

    // Entry i is the {a,b} pair applied as vector i: 00, 10, 11, 01.
    localparam logic [NUM_VECS-1:0][1:0] VEC_LUT = {2'b01, 2'b11, 2'b10, 2'b00};

    localparam int unsigned MASK_AND = 0;
    localparam int unsigned MASK_NOR = 1;
    localparam int unsigned MASK_XOR = 2;

    function automatic logic [2:0] expected(input logic a, input logic b);
        logic [2:0] r;
        r           = '0;
        r[MASK_AND] = a & b;
        r[MASK_NOR] = ~(a | b);
        r[MASK_XOR] = a ^ b;
        return r;
    endfunction

endpackage

// File: rtl/gate_vector_checker_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
// Brings the free-running gate outputs into the clk domain before comparison.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Drives every {a,b} combination into AND2/NOR2/XOR2 cells, samples their outputs after
// a settle time and logs mismatches against the truth table.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES = 6,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       z_and,
    input  logic       z_nor,
    input  logic       z_xor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] last_fail_vec,
    output logic [2:0] last_fail_mask
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    vec_idx;
    logic [7:0]    pass_idx;
    logic [2:0]    z_sync;
    logic [2:0]    fail_mask;
    logic          settle_end;
    logic          hold_end;
    logic          last_vec;
    logic          last_pass;
    logic          accept;
    logic          advance;
    logic          finish;

    sync2 #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({z_xor, z_nor, z_and}),
        .q     (z_sync)
    );

    // cnt counts edges since the current vector was applied (0 right after the apply edge).
    always_comb begin
        settle_end = (cnt == CW'(SETTLE_CYCLES - 2));
        hold_end   = (cnt == CW'(HOLD_CYCLES - 1));
        last_vec   = (vec_idx == 2'(NUM_VECS - 1));
        last_pass  = (pass_idx == 8'(NUM_PASSES - 1));
        accept     = (state == ST_IDLE) && start;
        advance    = (state == ST_HOLD) && hold_end && !(last_vec && last_pass);
        finish     = (state == ST_HOLD) && hold_end && last_vec && last_pass;
        fail_mask  = z_sync ^ expected(a, b);
        busy       = (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_HOLD);
        done       = (state == ST_DONE);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETTLE;
            ST_SETTLE: if (settle_end) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_HOLD;
            ST_HOLD: begin
                if (hold_end) state_next = (last_vec && last_pass) ? ST_DONE : ST_SETTLE;
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            vec_idx  <= '0;
            pass_idx <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
        end else begin
            if (accept || advance) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            if (accept) begin
                vec_idx  <= '0;
                pass_idx <= '0;
                {a, b}   <= VEC_LUT[2'd0];
            end else if (advance) begin
                vec_idx <= vec_idx + 2'd1;
                {a, b}  <= VEC_LUT[vec_idx + 2'd1];
                if (last_vec) pass_idx <= pass_idx + 8'd1;
            end else if (finish) begin
                {a, b} <= 2'b00;
            end
        end
    end

    // Count per sample, not per failing bit; the counter sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            pass           <= 1'b0;
            last_fail_vec  <= '0;
            last_fail_mask <= '0;
        end else if (accept) begin
            err_count      <= '0;
            pass           <= 1'b0;
            last_fail_vec  <= '0;
            last_fail_mask <= '0;
        end else begin
            if ((state == ST_SAMPLE) && (|fail_mask)) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                last_fail_vec  <= {a, b};
                last_fail_mask <= fail_mask;
            end
            if (finish) pass <= (err_count == 8'd0);
        end
    end

endmodule
